// File: rtl/cw_trace_capture_buffer.sv
// Trace capture buffer for ChipWatcher write-trace outputs: stores probe samples at the
// core-issued addresses, then streams the capture window out oldest-first over valid/ready.
module cw_trace_capture_buffer #(
  parameter int DATA_W    = 17,
  parameter int ADDR_W    = 10,
  parameter int WT_ADDR_W = 16
) (
  input  logic                 trig_clk,
  input  logic                 trig_rst,
  input  logic                 wt_ce,
  input  logic                 wt_en,
  input  logic [WT_ADDR_W-1:0] wt_addr,
  input  logic [DATA_W-1:0]    sample_din,
  input  logic                 abort,
  input  logic                 rd_start,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_last,
  output logic                 done,
  output logic                 busy,
  output logic [ADDR_W:0]      sample_count,
  output logic                 addr_err
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, READ} state_t;

  state_t state, state_nxt;

  logic              wr, wr_ok, wt_en_q;
  logic [ADDR_W-1:0] last_addr, rd_ptr, rd_addr, start_ptr;
  logic [ADDR_W:0]   issue_left, issue_base;
  logic              issue, issue_last;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              ram_vld, ram_last;

  // Two-entry skid buffer of {last, data}; absorbs the read in flight when rd_ready drops.
  logic [DATA_W:0]   skid [2];
  logic              skid_wp, skid_rp;
  logic [1:0]        skid_cnt, occ;
  logic              pop, last_pop;

  assign wr        = wt_ce & wt_en;
  assign wr_ok     = wr & ~abort & ((state == IDLE) | (state == CAPTURE));
  assign start_ptr = last_addr + ADDR_W'(1) - sample_count[ADDR_W-1:0];

  assign rd_valid  = (skid_cnt != 2'd0);
  assign rd_data   = skid[skid_rp][DATA_W-1:0];
  assign rd_last   = rd_valid & skid[skid_rp][DATA_W];
  assign pop       = rd_valid & rd_ready;
  assign last_pop  = pop & rd_last;
  assign occ       = skid_cnt + {1'b0, ram_vld};

  assign done      = (state == DONE);
  assign busy      = (state == CAPTURE) | (state == READ);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge trig_clk) begin
    if (trig_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (wr)                 state_nxt = CAPTURE;
      CAPTURE: if (wt_en_q && !wt_en)  state_nxt = DONE;
      DONE:    if (rd_start)           state_nxt = READ;
      READ:    if (last_pop)           state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // The first read is issued in the rd_start cycle itself so rd_valid appears two cycles later.
  always_comb begin
    issue      = 1'b0;
    rd_addr    = rd_ptr;
    issue_base = issue_left;
    if (!abort) begin
      if (state == DONE && rd_start) begin
        issue      = 1'b1;
        rd_addr    = start_ptr;
        issue_base = sample_count;
      end else if (state == READ && issue_left != '0 && (occ < 2'd2 || pop)) begin
        issue = 1'b1;
      end
    end
    issue_last = (issue_base == ONE);
  end

  // NOTE: the sample RAM is deliberately not reset; its contents are meaningless until written.
  always_ff @(posedge trig_clk) begin
    if (wr_ok) ram[wt_addr[ADDR_W-1:0]] <= sample_din;
    if (issue) ram_q <= ram[rd_addr];
  end

  always_ff @(posedge trig_clk) begin
    if (trig_rst) begin
      wt_en_q      <= 1'b0;
      sample_count <= '0;
      addr_err     <= 1'b0;
      last_addr    <= '0;
      rd_ptr       <= '0;
      issue_left   <= '0;
      ram_vld      <= 1'b0;
      ram_last     <= 1'b0;
      skid[0]      <= '0;
      skid[1]      <= '0;
      skid_wp      <= 1'b0;
      skid_rp      <= 1'b0;
      skid_cnt     <= 2'd0;
    end else begin
      wt_en_q <= wt_en;
      if (abort) begin
        sample_count <= '0;
        issue_left   <= '0;
        ram_vld      <= 1'b0;
        skid_wp      <= 1'b0;
        skid_rp      <= 1'b0;
        skid_cnt     <= 2'd0;
      end else begin
        if (wr_ok) begin
          last_addr <= wt_addr[ADDR_W-1:0];
          if (|wt_addr[WT_ADDR_W-1:ADDR_W]) addr_err <= 1'b1;
          if (state == IDLE)             sample_count <= ONE;
          else if (sample_count != FULL) sample_count <= sample_count + ONE;
        end
        if (issue) begin
          rd_ptr     <= rd_addr + ADDR_W'(1);
          issue_left <= issue_base - ONE;
        end
        ram_vld  <= issue;
        ram_last <= issue_last;
        if (ram_vld) begin
          skid[skid_wp] <= {ram_last, ram_q};
          skid_wp       <= ~skid_wp;
        end
        if (pop) skid_rp <= ~skid_rp;
        skid_cnt <= skid_cnt + 2'(ram_vld) - 2'(pop);
        if (last_pop) sample_count <= '0;
      end
    end
  end

endmodule
